// File: rtl/mat_mac_pkg.sv
// Shared types and defaults for the single-MAC matrix multiply engine.
package mat_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int MAT_DIM    = 8;
  localparam int MAT_DATA_W = 32;

  function automatic int idx_width(input int dim);
    return $clog2(dim * dim);
  endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Nested k (inner) / j / i (outer) element counter with wrap flags.
module mat_idx_counter #(
  parameter int DIM   = 8,
  parameter int CNT_W = $clog2(DIM)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             step_k,
  input  logic             step_ij,
  output logic [CNT_W-1:0] i,
  output logic [CNT_W-1:0] j,
  output logic [CNT_W-1:0] k,
  output logic             k_last,
  output logic             ij_last
);

  logic [CNT_W-1:0] i_reg, j_reg, k_reg;
  logic             j_last, i_last;

  assign i       = i_reg;
  assign j       = j_reg;
  assign k       = k_reg;
  assign k_last  = (k_reg == CNT_W'(DIM - 1));
  assign j_last  = (j_reg == CNT_W'(DIM - 1));
  assign i_last  = (i_reg == CNT_W'(DIM - 1));
  assign ij_last = i_last & j_last;

  // Advancing to the next output element always restarts the dot product at k=0.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      i_reg <= '0;
      j_reg <= '0;
      k_reg <= '0;
    end else if (step_ij) begin
      k_reg <= '0;
      if (j_last) begin
        j_reg <= '0;
        i_reg <= i_last ? '0 : i_reg + 1'b1;
      end else begin
        j_reg <= j_reg + 1'b1;
      end
    end else if (step_k) begin
      k_reg <= k_last ? '0 : k_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mat_mac_engine.sv
// Sequential C = A x B engine: one multiply-accumulate per cycle, one C write per element.
module mat_mac_engine
  import mat_mac_pkg::*;
#(
  parameter int DIM    = MAT_DIM,
  parameter int DATA_W = MAT_DATA_W,
  parameter int IDX_W  = idx_width(DIM)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [IDX_W-1:0]  a_addr_o,
  input  logic [DATA_W-1:0] a_rdata_i,
  output logic [IDX_W-1:0]  b_addr_o,
  input  logic [DATA_W-1:0] b_rdata_i,
  output logic              c_we_o,
  output logic [IDX_W-1:0]  c_addr_o,
  output logic [DATA_W-1:0] c_wdata_o
);

  localparam int CNT_W = IDX_W / 2;

  state_t              state_reg;
  logic                start_prev_reg;
  logic                busy_reg, done_reg, c_we_reg;
  logic [IDX_W-1:0]    c_addr_reg;
  logic [DATA_W-1:0]   c_wdata_reg, acc_reg;
  logic                issue_d_reg;
  logic [CNT_W-1:0]    k_d_reg;

  logic [CNT_W-1:0]    i_cnt, j_cnt, k_cnt;
  logic                k_last, ij_last;
  logic                start_rise, idle_like, cnt_clr;
  logic [DATA_W-1:0]   prod, acc_sum;

  assign start_rise = start_i & ~start_prev_reg;
  assign idle_like  = (state_reg == IDLE) || (state_reg == DONE);
  assign cnt_clr    = clear_i || (idle_like && start_rise);

  // Power-of-two DIM makes row-major addressing a plain concatenation.
  assign a_addr_o = {i_cnt, k_cnt};
  assign b_addr_o = {k_cnt, j_cnt};

  // Truncating multiply/add: wraps modulo 2^DATA_W, same bits signed or unsigned.
  assign prod    = a_rdata_i * b_rdata_i;
  assign acc_sum = ((k_d_reg == '0) ? '0 : acc_reg) + prod;

  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign c_we_o    = c_we_reg;
  assign c_addr_o  = c_addr_reg;
  assign c_wdata_o = c_wdata_reg;

  mat_idx_counter #(
    .DIM   (DIM),
    .CNT_W (CNT_W)
  ) u_idx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (cnt_clr),
    .step_k  (state_reg == ISSUE),
    .step_ij (state_reg == WRITE),
    .i       (i_cnt),
    .j       (j_cnt),
    .k       (k_cnt),
    .k_last  (k_last),
    .ij_last (ij_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      start_prev_reg <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      c_we_reg       <= 1'b0;
      c_addr_reg     <= '0;
      c_wdata_reg    <= '0;
      acc_reg        <= '0;
      issue_d_reg    <= 1'b0;
      k_d_reg        <= '0;
    end else begin
      start_prev_reg <= start_i;
      issue_d_reg    <= (state_reg == ISSUE) && !clear_i;
      k_d_reg        <= k_cnt;
      c_we_reg       <= 1'b0;
      if (issue_d_reg) begin
        acc_reg <= acc_sum;
      end
      if (clear_i) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            if (start_rise) begin
              state_reg <= ISSUE;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end
          end
          ISSUE: begin
            if (k_last) state_reg <= DRAIN;
          end
          // The final product arrives this cycle, so write the fresh sum directly.
          DRAIN: begin
            state_reg   <= WRITE;
            c_we_reg    <= 1'b1;
            c_addr_reg  <= {i_cnt, j_cnt};
            c_wdata_reg <= acc_sum;
          end
          WRITE: begin
            if (ij_last) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ISSUE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mat_mac_engine.sv
// Directed bench for mat_mac_engine with behavioural A/B read ports and a C write log.
module tb_mat_mac_engine;

  localparam int DIM     = 8;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 6;
  localparam int N       = DIM * DIM;
  localparam int RUN_CYC = 641;
  localparam int LOG_SZ  = 1024;

  logic              clk = 1'b0;
  logic              rst, start, clear;
  logic              busy, done, c_we;
  logic [IDX_W-1:0]  a_addr, b_addr, c_addr;
  logic [DATA_W-1:0] a_rdata, b_rdata, c_wdata;

  logic [DATA_W-1:0] a_mem [N];
  logic [DATA_W-1:0] b_mem [N];
  logic [7:0]        wr_addr_log [LOG_SZ];
  logic [DATA_W-1:0] wr_data_log [LOG_SZ];
  int                wr_cyc_log  [LOG_SZ];

  int cyc = 0;
  int wr_count = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mat_mac_engine #(.DIM(DIM), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .clear_i   (clear),
    .busy_o    (busy),
    .done_o    (done),
    .a_addr_o  (a_addr),
    .a_rdata_i (a_rdata),
    .b_addr_o  (b_addr),
    .b_rdata_i (b_rdata),
    .c_we_o    (c_we),
    .c_addr_o  (c_addr),
    .c_wdata_o (c_wdata)
  );

  // Synchronous read ports and a log of every C write with the cycle it occurred in.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    a_rdata <= a_mem[a_addr];
    b_rdata <= b_mem[b_addr];
    if (c_we) begin
      if (wr_count < LOG_SZ) begin
        wr_addr_log[wr_count] <= 8'(c_addr);
        wr_data_log[wr_count] <= c_wdata;
        wr_cyc_log[wr_count]  <= cyc;
      end
      wr_count <= wr_count + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(output int sc);
    start = 1'b1;
    sc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int sc, output int dc);
    dc = -1;
    while (dc < 0 && (cyc - sc) < 2000) begin
      if (done) dc = cyc;
      else step(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; clear = 1'b0;
    step(3);
    n_vec++;
    if ({busy, done, c_we} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: busy/done/we=%b expected 000", {busy, done, c_we});
    end
    n_vec++;
    if ({a_addr, b_addr, c_addr} !== '0 || c_wdata !== '0) begin
      n_err++; $display("FAIL reset_outputs: a=%0d b=%0d c=%0d wd=%h expected all 0", a_addr, b_addr, c_addr, c_wdata);
    end
    rst = 1'b0;
    step(10);
    n_vec++;
    if (busy !== 1'b0 || wr_count !== 0 || a_addr !== '0) begin
      n_err++; $display("FAIL reset_hold_start: busy=%b writes=%0d a_addr=%0d expected 0/0/0", busy, wr_count, a_addr);
    end
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL reset_reraise: busy=%b expected 1", busy);
    end
    start = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_abort: busy=%b expected 0", busy);
    end
    step(12);
  endtask

  task automatic test_identity();
    int sc, dc, base;
    for (int n = 0; n < N; n++) begin
      a_mem[n] = (n / DIM == n % DIM) ? 32'd1 : 32'd0;
      b_mem[n] = 32'(n + 1);
    end
    base = wr_count;
    launch(sc);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL identity_accept: busy=%b done=%b expected 1/0", busy, done);
    end
    wait_done(sc, dc);
    n_vec++;
    if (dc - sc !== RUN_CYC) begin
      n_err++; $display("FAIL identity_latency: done at +%0d expected +%0d", dc - sc, RUN_CYC);
    end
    n_vec++;
    if (wr_count - base !== N) begin
      n_err++; $display("FAIL identity_writes: %0d writes expected %0d", wr_count - base, N);
    end
    n_vec++;
    if (wr_cyc_log[base] - sc !== DIM + 2) begin
      n_err++; $display("FAIL identity_first_we: first write at +%0d expected +%0d", wr_cyc_log[base] - sc, DIM + 2);
    end
    for (int n = 0; n < N; n++) begin
      n_vec++;
      if (wr_addr_log[base + n] !== 8'(n) || wr_data_log[base + n] !== 32'(n + 1)) begin
        n_err++; $display("FAIL identity_c[%0d]: addr=%0d data=%0d expected addr=%0d data=%0d",
                          n, wr_addr_log[base + n], wr_data_log[base + n], n, n + 1);
      end
    end
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_err++; $display("FAIL identity_done: busy=%b done=%b expected 0/1", busy, done);
    end
  endtask

  task automatic test_wrap();
    int sc, dc, base;
    for (int n = 0; n < N; n++) begin
      a_mem[n] = 32'h0001_0000;
      b_mem[n] = 32'h0001_0000;
    end
    base = wr_count;
    launch(sc);
    wait_done(sc, dc);
    n_vec++;
    if (dc - sc !== RUN_CYC || wr_count - base !== N) begin
      n_err++; $display("FAIL wrap_run: done at +%0d with %0d writes expected +%0d with %0d", dc - sc, wr_count - base, RUN_CYC, N);
    end
    for (int n = 0; n < N; n++) begin
      n_vec++;
      if (wr_addr_log[base + n] !== 8'(n) || wr_data_log[base + n] !== 32'd0) begin
        n_err++; $display("FAIL wrap_zero_c[%0d]: addr=%0d data=%h expected addr=%0d data=0", n, wr_addr_log[base + n], wr_data_log[base + n], n);
      end
    end
    for (int n = 0; n < N; n++) begin
      a_mem[n] = 32'd3;
      b_mem[n] = 32'd3;
    end
    base = wr_count;
    launch(sc);
    wait_done(sc, dc);
    n_vec++;
    if (dc - sc !== RUN_CYC || wr_count - base !== N) begin
      n_err++; $display("FAIL wrap_rerun: done at +%0d with %0d writes expected +%0d with %0d", dc - sc, wr_count - base, RUN_CYC, N);
    end
    for (int n = 0; n < N; n++) begin
      n_vec++;
      if (wr_addr_log[base + n] !== 8'(n) || wr_data_log[base + n] !== 32'd72) begin
        n_err++; $display("FAIL wrap_three_c[%0d]: addr=%0d data=%0d expected addr=%0d data=72", n, wr_addr_log[base + n], wr_data_log[base + n], n);
      end
    end
  endtask

  task automatic test_busy_start();
    int sc, dc, base;
    for (int n = 0; n < N; n++) begin
      a_mem[n] = (n / DIM == n % DIM) ? 32'd1 : 32'd0;
      b_mem[n] = 32'(3 * n + 1);
    end
    base = wr_count;
    launch(sc);
    step(99);
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_start_busy: busy=%b expected 1", busy);
    end
    wait_done(sc, dc);
    n_vec++;
    if (dc - sc !== RUN_CYC) begin
      n_err++; $display("FAIL busy_start_latency: done at +%0d expected +%0d", dc - sc, RUN_CYC);
    end
    n_vec++;
    if (wr_count - base !== N) begin
      n_err++; $display("FAIL busy_start_writes: %0d writes expected %0d", wr_count - base, N);
    end
    for (int n = 0; n < N; n++) begin
      n_vec++;
      if (wr_addr_log[base + n] !== 8'(n) || wr_data_log[base + n] !== 32'(3 * n + 1)) begin
        n_err++; $display("FAIL busy_start_c[%0d]: addr=%0d data=%0d expected addr=%0d data=%0d",
                          n, wr_addr_log[base + n], wr_data_log[base + n], n, 3 * n + 1);
      end
    end
  endtask

  task automatic test_abort();
    int sc, dc, base, wc;
    base = wr_count;
    launch(sc);
    step(199);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    wc = wr_count;
    n_vec++;
    if ({c_we, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL abort_flags: we/busy/done=%b expected 000", {c_we, busy, done});
    end
    n_vec++;
    if (wc - base !== 20) begin
      n_err++; $display("FAIL abort_prior_writes: %0d writes expected 20", wc - base);
    end
    step(30);
    n_vec++;
    if (wr_count !== wc || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: %0d extra writes busy=%b done=%b expected 0/0/0", wr_count - wc, busy, done);
    end
    for (int n = 0; n < N; n++) b_mem[n] = 32'(n + 7);
    base = wr_count;
    launch(sc);
    wait_done(sc, dc);
    n_vec++;
    if (dc - sc !== RUN_CYC || wr_count - base !== N) begin
      n_err++; $display("FAIL abort_restart: done at +%0d with %0d writes expected +%0d with %0d", dc - sc, wr_count - base, RUN_CYC, N);
    end
    for (int n = 0; n < N; n++) begin
      n_vec++;
      if (wr_addr_log[base + n] !== 8'(n) || wr_data_log[base + n] !== 32'(n + 7)) begin
        n_err++; $display("FAIL abort_restart_c[%0d]: addr=%0d data=%0d expected addr=%0d data=%0d",
                          n, wr_addr_log[base + n], wr_data_log[base + n], n, n + 7);
      end
    end
  endtask

  task automatic test_clear_vs_start();
    int wc;
    wc = wr_count;
    start = 1'b1;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL clear_start_edge: busy=%b done=%b expected 0/0", busy, done);
    end
    step(15);
    n_vec++;
    if (busy !== 1'b0 || wr_count !== wc || a_addr !== '0 || b_addr !== '0) begin
      n_err++; $display("FAIL clear_start_idle: busy=%b writes=%0d a=%0d b=%0d expected 0/0/0/0", busy, wr_count - wc, a_addr, b_addr);
    end
    start = 1'b0;
    step(2);
  endtask

  initial begin
    for (int n = 0; n < N; n++) begin
      a_mem[n] = '0;
      b_mem[n] = '0;
    end
    test_reset();
    test_identity();
    test_wrap();
    test_busy_start();
    test_abort();
    test_clear_vs_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
